// File: rtl/divider_pkg.sv
// Shared definitions for the repeated-subtraction divider controller:
// FSM encodings, datapath widths and the round-robin index wrap helper.
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int DIV_W   = 8;
  localparam int CYC_W   = 16;
  localparam int MAX_REQ = 4;
  localparam logic [DIV_W-1:0] DZ_QUOTIENT = 8'hFF;

  // Wrap base into 0..n-1; base never reaches 2n so one subtraction suffices.
  function automatic logic [1:0] rr_wrap(input logic [2:0] base, input logic [2:0] n);
    logic [2:0] r;
    r = (base >= n) ? base - n : base;
    return r[1:0];
  endfunction

endpackage

// File: rtl/divider_rr_arb.sv
// Combinational round-robin winner select. The scan starts at rr_ptr and
// wraps modulo NREQ; the pointer register itself lives in the caller.
module divider_rr_arb
  import divider_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [1:0]      rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      win_idx,
  output logic            win_any
);

  logic [MAX_REQ-1:0] req_ext;

  assign req_ext = MAX_REQ'(req_valid);

  // First set request at or after rr_ptr wins
  always_comb begin
    logic [1:0] cand;
    cand    = '0;
    win_idx = '0;
    win_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_wrap({1'b0, rr_ptr} + 3'(k), 3'(NREQ));
      if (!win_any && req_ext[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  // One-hot form of the winning index
  always_comb begin
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = win_any && (2'(i) == win_idx);
    end
  end

endmodule

// File: rtl/divider_sched.sv
// Shared controller for the 8-bit repeated-subtraction divider.
// Arbitrates up to four requesters round-robin, runs one compare-and-subtract
// per cycle and returns quotient/remainder to the owning requester.
// Optional macro DIVIDER_SCHED_CYCCNT_EN enables the cyc_count register.
//
// Handshakes: a requester holds req_valid and its operands until it sees the
// one-cycle req_grant pulse, which is also the capture cycle. The result is
// offered with rsp_valid[owner] and held until rsp_ack[owner] is sampled high
// on a clock edge; acks from other requesters or outside DONE are ignored.
module divider_sched
  import divider_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  ClkPort,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DIV_W-1:0] req_dividend,
  input  logic [NREQ*DIV_W-1:0] req_divisor,
  output logic [NREQ-1:0]       req_grant,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ack,
  output logic [DIV_W-1:0]      quotient,
  output logic [DIV_W-1:0]      remainder,
  output logic                  div_by_zero,
  output logic                  busy,
  output logic                  Qi,
  output logic                  Qc,
  output logic                  Qd,
  output logic [CYC_W-1:0]      cyc_count
);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] rem_r, div_r, quo_r;
  logic             dz_r;
  logic [1:0]       owner, rr_ptr;
  logic [NREQ-1:0]  arb_grant;
  logic [1:0]       win_idx;
  logic             win_any;
  logic [DIV_W-1:0] sel_dvd, sel_dvs;
  logic [NREQ-1:0]  own_onehot;
  logic             take, div_zero, can_sub, ack_own;

  divider_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .win_idx   (win_idx),
    .win_any   (win_any)
  );

  assign take     = (state == ST_IDLE) && win_any && !Reset;
  assign div_zero = (div_r == '0);
  assign can_sub  = (rem_r >= div_r);

  // Operand mux for the arbitration winner
  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (2'(i) == win_idx) begin
        sel_dvd = req_dividend[i*DIV_W +: DIV_W];
        sel_dvs = req_divisor[i*DIV_W +: DIV_W];
      end
    end
  end

  // One-hot owner and the owner's ack
  always_comb begin
    own_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      own_onehot[i] = (2'(i) == owner);
    end
  end

  assign ack_own = |(rsp_ack & own_onehot);

  // FSM state register
  always_ff @(posedge ClkPort) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (win_any) state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (div_zero || !can_sub) state_nxt = ST_DONE;
      ST_DONE:    if (ack_own) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture on grant, one subtraction per COMPUTE cycle
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      rem_r  <= '0;
      div_r  <= '0;
      quo_r  <= '0;
      dz_r   <= 1'b0;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (take) begin
      rem_r  <= sel_dvd;
      div_r  <= sel_dvs;
      quo_r  <= '0;
      dz_r   <= 1'b0;
      owner  <= win_idx;
      rr_ptr <= (win_idx == 2'(NREQ-1)) ? 2'd0 : win_idx + 2'd1;
    end else if (state == ST_COMPUTE) begin
      if (div_zero) begin
        dz_r <= 1'b1;
      end else if (can_sub) begin
        rem_r <= rem_r - div_r;
        quo_r <= quo_r + 8'd1;
      end
    end
  end

`ifdef DIVIDER_SCHED_CYCCNT_EN
  logic [CYC_W-1:0] cyc_r;

  // Iteration counter: cleared on grant, counts COMPUTE cycles, then holds
  always_ff @(posedge ClkPort) begin
    if (Reset)                    cyc_r <= '0;
    else if (take)                cyc_r <= '0;
    else if (state == ST_COMPUTE) cyc_r <= cyc_r + CYC_W'(1);
  end

  assign cyc_count = cyc_r;
`else
  assign cyc_count = '0;
`endif

  // Remainder register still holds the dividend after a divide-by-zero
  assign req_grant   = take ? arb_grant : '0;
  assign rsp_valid   = (state == ST_DONE) ? own_onehot : '0;
  assign quotient    = dz_r ? DZ_QUOTIENT : quo_r;
  assign remainder   = rem_r;
  assign div_by_zero = dz_r;
  assign busy        = (state != ST_IDLE);
  assign Qi          = (state == ST_IDLE);
  assign Qc          = (state == ST_COMPUTE);
  assign Qd          = (state == ST_DONE);

endmodule

// File: tb/tb_divider_sched.sv
// Directed bench for divider_sched: table of single divisions plus
// hand-written sequences for arbitration, stray acks and reset mid-operation.
module tb_divider_sched;
  import divider_pkg::*;

  localparam int NREQ = 2;
`ifdef DIVIDER_SCHED_CYCCNT_EN
  localparam bit CYC_ON = 1'b1;
`else
  localparam bit CYC_ON = 1'b0;
`endif

  logic                  ClkPort = 1'b0;
  logic                  Reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DIV_W-1:0] req_dividend, req_divisor;
  logic [NREQ-1:0]       req_grant, rsp_valid, rsp_ack;
  logic [DIV_W-1:0]      quotient, remainder;
  logic                  div_by_zero, busy, Qi, Qc, Qd;
  logic [CYC_W-1:0]      cyc_count;

  typedef struct {
    int         req;
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] eq;
    logic [7:0] er;
    logic       edz;
    int         lat;
    int         cyc;
  } vec_t;

  vec_t        vecs[8];
  logic [16:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Clock and DUT
  always #5 ClkPort = ~ClkPort;

  divider_sched #(.NREQ(NREQ)) dut (
    .ClkPort      (ClkPort),
    .Reset        (Reset),
    .req_valid    (req_valid),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .req_grant    (req_grant),
    .rsp_valid    (rsp_valid),
    .rsp_ack      (rsp_ack),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .busy         (busy),
    .Qi           (Qi),
    .Qc           (Qc),
    .Qd           (Qd),
    .cyc_count    (cyc_count)
  );

  function automatic logic [NREQ-1:0] oh(input int r);
    logic [NREQ-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input int r, input logic [7:0] dvd, input logic [7:0] dvs);
    req_dividend[r*8 +: 8] = dvd;
    req_divisor[r*8 +: 8]  = dvs;
  endtask

  // Wait (bounded) for any grant; returns number of extra cycles waited
  task automatic wait_grant(output int n);
    n = 0;
    #1;
    while (req_grant == '0 && n < 10) begin
      @(negedge ClkPort);
      #1;
      n++;
    end
  endtask

  // Wait (bounded) for rsp_valid, counting negedges since the grant cycle
  task automatic wait_rsp(inout int n);
    while (rsp_valid == '0 && n < 400) begin
      @(negedge ClkPort);
      #1;
      n++;
    end
  endtask

  // Compare the response against the head of the expected queue
  task automatic check_rsp(input int r, input int exp_cyc);
    logic [16:0] e;
    e = exp_q.pop_front();
    check("rsp_valid", rsp_valid, oh(r));
    check("quotient", quotient, e[16:9]);
    check("remainder", remainder, e[8:1]);
    check("div_by_zero", div_by_zero, e[0]);
    check("cyc_count", cyc_count, CYC_ON ? exp_cyc : 0);
    check("Qd", {Qi, Qc, Qd, busy}, 4'b0011);
  endtask

  task automatic ack_and_check(input int r);
    rsp_ack = oh(r);
    @(negedge ClkPort);
    rsp_ack = '0;
    #1;
    check("rsp_valid_after_ack", rsp_valid, 0);
    check("idle_after_ack", {Qi, Qc, Qd, busy}, 4'b1000);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge ClkPort);
    set_ops(v.req, v.dvd, v.dvs);
    req_valid = oh(v.req);
    #1;
    check("grant", req_grant, oh(v.req));
    exp_q.push_back({v.eq, v.er, v.edz});
    @(negedge ClkPort);
    #1;
    check("grant_pulse_once", req_grant, 0);
    check("compute_state", {Qi, Qc, Qd, busy}, 4'b0101);
    // Operands changing after the grant must not matter
    req_valid = '0;
    set_ops(v.req, 8'hA5, 8'h03);
    n = 1;
    wait_rsp(n);
    check("latency", n, v.lat);
    check_rsp(v.req, v.cyc);
    ack_and_check(v.req);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge ClkPort);
    Reset = 1'b1;
    repeat (cycles) @(negedge ClkPort);
    Reset = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    Reset        = 1'b1;
    req_valid    = '0;
    rsp_ack      = '0;
    req_dividend = '0;
    req_divisor  = '0;

    vecs[0] = '{0, 8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 16,  15};
    vecs[1] = '{1, 8'd9,   8'd0,   8'hFF,  8'd9, 1'b1, 2,   1};
    vecs[2] = '{0, 8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 257, 256};
    vecs[3] = '{1, 8'd3,   8'd200, 8'd0,   8'd3, 1'b0, 2,   1};
    vecs[4] = '{0, 8'd200, 8'd200, 8'd1,   8'd0, 1'b0, 3,   2};
    vecs[5] = '{1, 8'd0,   8'd5,   8'd0,   8'd0, 1'b0, 2,   1};
    vecs[6] = '{0, 8'd0,   8'd0,   8'hFF,  8'd0, 1'b1, 2,   1};
    vecs[7] = '{1, 8'd37,  8'd6,   8'd6,   8'd1, 1'b0, 8,   7};

    // Reset values
    repeat (3) @(negedge ClkPort);
    #1;
    check("reset_state", {Qi, Qc, Qd, busy}, 4'b1000);
    check("reset_grant", req_grant, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_result", {quotient, remainder, div_by_zero}, 0);
    check("reset_cyc_count", cyc_count, 0);
    Reset = 1'b0;

    // Table of single divisions
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Both requesters hold req_valid: grants alternate starting at 0
    do_reset(2);
    set_ops(0, 8'd20, 8'd5);
    set_ops(1, 8'd7, 8'd2);
    req_valid = 2'b11;
    for (int it = 0; it < 4; it++) begin
      int own;
      own = it % 2;
      wait_grant(n);
      check("rr_grant", req_grant, oh(own));
      if (own == 0) exp_q.push_back({8'd4, 8'd0, 1'b0});
      else          exp_q.push_back({8'd3, 8'd1, 1'b0});
      @(negedge ClkPort);
      #1;
      n = 1;
      wait_rsp(n);
      check_rsp(own, own == 0 ? 5 : 4);
      if (it == 0) begin
        // Ack from the non-owner is ignored
        rsp_ack = 2'b10;
        @(negedge ClkPort);
        rsp_ack = '0;
        #1;
        check("stray_ack_ignored", {rsp_valid, Qd}, {2'b01, 1'b1});
      end
      rsp_ack = oh(own);
      @(negedge ClkPort);
      rsp_ack = '0;
      #1;
      check("rr_rsp_dropped", rsp_valid, 0);
    end
    req_valid = '0;

    // Reset in the middle of 200 / 1, owned by requester 0 (rr_ptr becomes 1)
    @(negedge ClkPort);
    @(negedge ClkPort);
    set_ops(0, 8'd200, 8'd1);
    req_valid = 2'b01;
    #1;
    check("mid_grant", req_grant, 2'b01);
    @(negedge ClkPort);
    req_valid = '0;
    repeat (10) @(negedge ClkPort);
    #1;
    check("mid_still_compute", {Qi, Qc, Qd, busy}, 4'b0101);
    Reset = 1'b1;
    @(negedge ClkPort);
    #1;
    check("mid_reset_state", {Qi, Qc, Qd, busy}, 4'b1000);
    check("mid_reset_rsp", rsp_valid, 0);
    req_valid = 2'b11;
    #1;
    check("grant_held_in_reset", req_grant, 0);
    req_valid = '0;
    Reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge ClkPort);
      #1;
      if (rsp_valid != '0 || !Qi) seen++;
    end
    check("no_rsp_after_reset", seen, 0);

    // rr_ptr restarted at 0: requester 0 wins
    set_ops(0, 8'd50, 8'd10);
    set_ops(1, 8'd60, 8'd10);
    req_valid = 2'b11;
    #1;
    check("rr_ptr_reset", req_grant, 2'b01);
    exp_q.push_back({8'd5, 8'd0, 1'b0});
    @(negedge ClkPort);
    req_valid = '0;
    #1;
    n = 1;
    wait_rsp(n);
    check("post_reset_latency", n, 7);
    check_rsp(0, 6);
    ack_and_check(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
